// File: rtl/spi_master_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_master_param
//  Purpose  : Parametrised full-duplex SPI master. Word width, SCLK divider,
//             MISO synchroniser depth and slave-select count are parameters;
//             CPOL/CPHA and the target slave are chosen per transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_param #(
    parameter int DATA_W = 16,
    parameter int DIV    = 32,
    parameter int NUM_SS = 4,
    parameter int NSYNC  = 2,
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [DATA_W-1:0] cmd,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] SPI_data_out
);

    localparam int CW = $clog2(DIV);
    localparam int BW = $clog2(DATA_W);

    localparam logic [CW-1:0] c_half      = CW'(DIV / 2);
    localparam logic [CW-1:0] c_half_last = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] c_div_last  = CW'(DIV - 1);
    localparam logic [BW-1:0] c_bit_last  = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XFER  = 3'd2,
        TRAIL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [BW-1:0]       r_bit;
    logic [BW-1:0]       w_bit_nxt;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [NSYNC-1:0]    r_sync;
    logic                r_cpol;
    logic                r_cpha;
    logic [SS_W-1:0]     r_ss;
    logic                r_sclk;
    logic [NUM_SS-1:0]   r_ss_n;
    logic [DATA_W-1:0]   r_data_out;

    logic                w_accept;
    logic                w_capture;
    logic                w_cpol_nxt;
    logic                w_cpha_nxt;
    logic [SS_W-1:0]     w_ss_nxt;
    logic                w_sclk_nxt;
    logic [NUM_SS-1:0]   w_ss_n_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter sequencing and next values of the registered pins
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_accept    = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            IDLE: begin
                if (wrt) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LEAD;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            LEAD: begin
                if (r_cnt == c_half_last) begin
                    w_state_nxt = XFER;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            XFER: begin
                if (r_cnt == c_div_last) begin
                    w_capture = 1'b1;
                    w_cnt_nxt = '0;
                    if (r_bit == c_bit_last) begin
                        w_state_nxt = TRAIL;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            TRAIL: begin
                if (r_cnt == c_half_last) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Transfer settings are taken from the ports on the accepting edge
        w_cpol_nxt = w_accept ? cpol   : r_cpol;
        w_cpha_nxt = w_accept ? cpha   : r_cpha;
        w_ss_nxt   = w_accept ? ss_sel : r_ss;

        // SCLK rests at CPOL except while shifting; CPHA swaps the half-periods
        w_sclk_nxt = w_cpol_nxt;
        if (w_state_nxt == XFER) begin
            w_sclk_nxt = w_cpol_nxt ^ w_cpha_nxt ^ (w_cnt_nxt >= c_half);
        end

        // An out-of-range slave index simply selects nobody
        w_ss_n_nxt = '1;
        if ((w_state_nxt == LEAD) || (w_state_nxt == XFER) || (w_state_nxt == TRAIL)) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (32'(w_ss_nxt) == i) begin
                    w_ss_n_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Datapath: counters, shift registers, MISO synchroniser and pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_sync     <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_ss       <= '0;
            r_sclk     <= 1'b0;
            r_ss_n     <= '1;
            r_data_out <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_bit  <= w_bit_nxt;
            r_sync <= {r_sync[NSYNC-2:0], MISO};
            r_cpol <= w_cpol_nxt;
            r_cpha <= w_cpha_nxt;
            r_ss   <= w_ss_nxt;
            r_sclk <= w_sclk_nxt;
            r_ss_n <= w_ss_n_nxt;
            if (w_accept) begin
                r_tx <= cmd;
                r_rx <= '0;
            end else if (w_capture) begin
                // MOSI only moves on bit boundaries, together with the capture
                r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                r_rx <= {r_rx[DATA_W-2:0], r_sync[NSYNC-1]};
            end
            if ((r_state == TRAIL) && (w_state_nxt == DONE)) begin
                r_data_out <= r_rx;
            end
        end
    end

    assign SCLK         = r_sclk;
    assign MOSI         = r_tx[DATA_W-1];
    assign SS_n         = r_ss_n;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign SPI_data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_param
//  Purpose  : Scoreboard bench for spi_master_param. Two instances: defaults
//             (16-bit, DIV 32, 4 selects) and a small one (8-bit, DIV 8,
//             3 selects, so ss_sel=3 is out of range). A behavioural SPI slave
//             per instance answers on MISO and records what it received.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_param;

    localparam int W0 = 16, D0 = 32, N0 = 4;
    localparam int W1 = 8,  D1 = 8,  N1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrt    [2];
    logic [15:0] cmd    [2];
    logic [1:0]  ss_sel [2];
    logic        cpol   [2];
    logic        cpha   [2];
    logic        miso   [2];
    logic        sclk   [2];
    logic        mosi   [2];
    logic        busy   [2];
    logic        done   [2];
    logic [15:0] dout   [2];
    logic [3:0]  ssn    [2];
    logic [2:0]  ssn1_raw;
    logic [7:0]  dout1_raw;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(W0), .DIV(D0), .NUM_SS(N0), .NSYNC(2)) u_dut0 (
        .clk(clk), .rst(rst), .wrt(wrt[0]), .cmd(cmd[0]), .ss_sel(ss_sel[0]),
        .cpol(cpol[0]), .cpha(cpha[0]), .MISO(miso[0]), .SCLK(sclk[0]),
        .MOSI(mosi[0]), .SS_n(ssn[0]), .busy(busy[0]), .done(done[0]),
        .SPI_data_out(dout[0])
    );

    spi_master_param #(.DATA_W(W1), .DIV(D1), .NUM_SS(N1), .NSYNC(2)) u_dut1 (
        .clk(clk), .rst(rst), .wrt(wrt[1]), .cmd(cmd[1][7:0]), .ss_sel(ss_sel[1]),
        .cpol(cpol[1]), .cpha(cpha[1]), .MISO(miso[1]), .SCLK(sclk[1]),
        .MOSI(mosi[1]), .SS_n(ssn1_raw), .busy(busy[1]), .done(done[1]),
        .SPI_data_out(dout1_raw)
    );

    assign ssn[1]  = {1'b1, ssn1_raw};
    assign dout[1] = {8'h00, dout1_raw};

    typedef struct packed {
        logic [15:0] cmd;
        logic [15:0] slv;
        logic        loop;
        logic        cpol;
        logic        cpha;
        logic [1:0]  ss;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wid(input int d);  return (d == 0) ? W0 : W1; endfunction
    function automatic int dv(input int d);   return (d == 0) ? D0 : D1; endfunction
    function automatic int nss(input int d);  return (d == 0) ? N0 : N1; endfunction
    function automatic logic [15:0] wmask(input int d);
        return (d == 0) ? 16'hFFFF : 16'h00FF;
    endfunction

    // Slave selects a transfer should show: one low bit, or none when out of range
    function automatic logic [3:0] exp_ssn(input int d, input logic [1:0] s);
        logic [3:0] r;
        r = 4'hF;
        if (int'(s) < nss(d)) r[s] = 1'b0;
        return r;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction
    function automatic exp_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor + behavioural slave -------------------------
    bit          act   [2];
    bit          post  [2];
    bit          pbusy [2];
    bit          prevs [2];
    bit          pcpol [2];
    logic [15:0] srx   [2];
    int          lead  [2];
    int          ssbad [2];
    int          k     [2];
    exp_t        cur   [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                act[d]   = 1'b0;
                post[d]  = 1'b0;
                pbusy[d] = 1'b0;
                miso[d]  = 1'b0;
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                if (post[d]) begin
                    post[d] = 1'b0;
                    check($sformatf("idle_busy%0d", d), 32'(busy[d]), 32'd0);
                    check($sformatf("idle_sclk%0d", d), 32'(sclk[d]), 32'(pcpol[d]));
                end
                if (busy[d] && !pbusy[d]) begin
                    if (qsize(d) == 0) begin
                        flag($sformatf("spurious_start%0d", d));
                    end else begin
                        cur[d] = qfront(d);
                        check($sformatf("accept_cycle%0d", d), 32'(cyc), 32'(cur[d].acc));
                        act[d]   = 1'b1;
                        srx[d]   = '0;
                        lead[d]  = 0;
                        ssbad[d] = 0;
                        prevs[d] = sclk[d];
                        k[d]     = cur[d].cpha ? 0 : 1;
                        if (!cur[d].loop && !cur[d].cpha)
                            miso[d] = cur[d].slv[wid(d)-1];
                    end
                end else if (act[d] && (sclk[d] != prevs[d])) begin
                    if (sclk[d] != cur[d].cpol) begin
                        // leading edge
                        lead[d]++;
                        if (!cur[d].cpha) srx[d] = {srx[d][14:0], mosi[d]};
                        else if (!cur[d].loop && k[d] < wid(d)) begin
                            miso[d] = cur[d].slv[wid(d)-1-k[d]];
                            k[d]++;
                        end
                    end else begin
                        // trailing edge
                        if (cur[d].cpha) srx[d] = {srx[d][14:0], mosi[d]};
                        else if (!cur[d].loop && k[d] < wid(d)) begin
                            miso[d] = cur[d].slv[wid(d)-1-k[d]];
                            k[d]++;
                        end
                    end
                    prevs[d] = sclk[d];
                end
                if (act[d] && cur[d].loop) miso[d] = mosi[d];
                if (act[d] && busy[d] && !done[d] && (ssn[d] !== exp_ssn(d, cur[d].ss)))
                    ssbad[d]++;
                if (done[d]) begin
                    if (qsize(d) == 0 || !act[d]) begin
                        flag($sformatf("spurious_done%0d", d));
                    end else begin
                        check($sformatf("latency%0d", d), 32'(cyc - cur[d].acc),
                              32'(dv(d) + wid(d) * dv(d)));
                        check($sformatf("data_out%0d", d), 32'(dout[d]),
                              32'(cur[d].loop ? cur[d].cmd : cur[d].slv));
                        check($sformatf("slave_rx%0d", d), 32'(srx[d]), 32'(cur[d].cmd));
                        check($sformatf("sclk_pulses%0d", d), 32'(lead[d]), 32'(wid(d)));
                        check($sformatf("ss_bad_cycles%0d", d), 32'(ssbad[d]), 32'd0);
                        check($sformatf("ss_done%0d", d), 32'(ssn[d]), 32'hF);
                        pcpol[d] = cur[d].cpol;
                        act[d]   = 1'b0;
                        post[d]  = 1'b1;
                        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    end
                end
                pbusy[d] = busy[d];
            end
        end
    end

    // ---------------- driver ----------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d);
        int t = 0;
        while (busy[d] && t < 2000) begin tick(); t++; end
        if (t >= 2000) flag($sformatf("timeout_idle%0d", d));
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while (!done[d] && t < 2000) begin tick(); t++; end
        if (t >= 2000) flag($sformatf("timeout_done%0d", d));
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic issue(input int d, input logic [15:0] c, input logic [1:0] s,
                         input bit po, input bit ph, input bit lp,
                         input logic [15:0] sv, input bit hold);
        exp_t e;
        wait_idle(d);
        e.cmd = c & wmask(d); e.slv = sv & wmask(d); e.loop = lp;
        e.cpol = po; e.cpha = ph; e.ss = s; e.acc = cyc + 1;
        wrt[d] = 1'b1; cmd[d] = e.cmd; ss_sel[d] = s; cpol[d] = po; cpha[d] = ph;
        push(d, e);
        tick();
        if (!hold) begin
            // Scramble the ports: the transfer must run on latched values
            wrt[d]    = 1'b0;
            cmd[d]    = 16'($urandom);
            ss_sel[d] = 2'($urandom);
            cpol[d]   = 1'($urandom);
            cpha[d]   = 1'($urandom);
        end
    endtask

    initial begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            wrt[d] = 0; cmd[d] = 0; ss_sel[d] = 0; cpol[d] = 0; cpha[d] = 0;
        end
        rst = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ssn%0d", d),  32'(ssn[d]),  32'hF);
            check($sformatf("rst_sclk%0d", d), 32'(sclk[d]), 32'd0);
            check($sformatf("rst_mosi%0d", d), 32'(mosi[d]), 32'd0);
            check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
            check($sformatf("rst_done%0d", d), 32'(done[d]), 32'd0);
            check($sformatf("rst_dout%0d", d), 32'(dout[d]), 32'd0);
        end
        rst = 1'b0;
        tick();

        // Directed transfers
        issue(0, 16'hA5C3, 2'd0, 0, 0, 1, 16'h0000, 0);
        tick();
        check("ss_sel0_lead", 32'(ssn[0]), 32'hE);
        issue(0, 16'hDEAD, 2'd2, 1, 1, 0, 16'hBEEF, 0);
        issue(1, 16'h003C, 2'd0, 0, 1, 1, 16'h0000, 0);
        issue(1, 16'h0081, 2'd3, 1, 0, 0, 16'h00E7, 0);

        // Randomised transfers on both instances, overlapping in time
        for (int i = 0; i < 16; i++) begin
            int d = i % 2;
            issue(d, 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 1'($urandom), 16'($urandom), 0);
        end

        // wrt held high: one transfer per IDLE entry, next accepted right after
        wait_idle(0);
        issue(0, 16'h1234, 2'd1, 0, 1, 1, 16'h0000, 1);
        wait_done(0);
        e.cmd = 16'h1234; e.slv = 16'h0; e.loop = 1; e.cpol = 0; e.cpha = 1;
        e.ss = 2'd1; e.acc = cyc + 2;
        push(0, e);
        tick();
        tick();
        wrt[0] = 1'b0;

        // wrt pulse only in the DONE cycle must not start a transfer
        wait_done(0);
        wrt[0] = 1'b1;
        tick();
        wrt[0] = 1'b0;
        repeat (3) tick();
        check("no_restart_after_done", 32'(busy[0]), 32'd0);

        // Reset mid-transfer
        wait_idle(1);
        issue(0, 16'h5A5A, 2'd3, 1, 0, 1, 16'h0000, 0);
        repeat (198) tick();
        rst = 1'b1;
        tick();
        check("abort_ssn",  32'(ssn[0]),  32'hF);
        check("abort_sclk", 32'(sclk[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_dout", 32'(dout[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        rst = 1'b0;
        tick();
        issue(0, 16'hC0DE, 2'd1, 0, 0, 0, 16'h7E81, 0);

        // Drain the scoreboards
        begin
            int t = 0;
            while ((q0.size() != 0 || q1.size() != 0) && t < 3000) begin tick(); t++; end
            if (t >= 3000) flag("timeout_drain");
        end
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
